// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and round-logic helpers.
// Used by sha1_round (combinational round) and sha1_engine (block engine).
package sha1_pkg;

    localparam logic [31:0] H0INIT = 32'h67452301;
    localparam logic [31:0] H1INIT = 32'hefcdab89;
    localparam logic [31:0] H2INIT = 32'h98badcfe;
    localparam logic [31:0] H3INIT = 32'h10325476;
    localparam logic [31:0] H4INIT = 32'hc3d2e1f0;
    localparam logic [159:0] HINIT = {H0INIT, H1INIT, H2INIT, H3INIT, H4INIT};

    localparam logic [31:0] K0 = 32'h5a827999;
    localparam logic [31:0] K1 = 32'h6ed9eba1;
    localparam logic [31:0] K2 = 32'h8f1bbcdc;
    localparam logic [31:0] K3 = 32'hca62c1d6;

    localparam int NROUNDS = 80;

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] parity(input logic [31:0] b, input logic [31:0] c,
                                           input logic [31:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
        return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [31:0] k_of(input logic [6:0] t);
        if (t < 7'd20)      return K0;
        else if (t < 7'd40) return K1;
        else if (t < 7'd60) return K2;
        else                return K3;
    endfunction

    function automatic logic [31:0] f_of(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)                     return ch(b, c, d);
        else if (t >= 7'd40 && t < 7'd60)  return maj(b, c, d);
        else                               return parity(b, c, d);
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One SHA-1 compression round, purely combinational (zero latency, no handshake).
// f_t and K_t are chosen from this stage's own round index t.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] w,
    input  logic [6:0]  t,
    output logic [31:0] aNext,
    output logic [31:0] bNext,
    output logic [31:0] cNext,
    output logic [31:0] dNext,
    output logic [31:0] eNext
);

    logic [31:0] temp;

    assign temp  = rotl(a, 5) + f_of(t, b, c, d) + e + k_of(t) + w;
    assign aNext = temp;
    assign bNext = a;
    assign cNext = rotl(b, 30);
    assign dNext = c;
    assign eNext = d;

endmodule

// File: rtl/sha1_engine.sv
// SHA-1 block engine: 16 words in over valid/ready, 80 rounds at ROUNDS_PER_CYCLE per clock, then H update.
// Latency 80/R+1 edges from word 15 to oDone; oReady low outside LOAD, input stalls tolerated indefinitely.
module sha1_engine
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int WORDSIZE         = 32
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [31:0]  iDat,
    input  logic         iValid,
    input  logic         iInitial,
    output logic         oReady,
    output logic [159:0] oDat,
    output logic         oDone
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : gBadRounds
        $error("sha1_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
    end
    if (WORDSIZE != 32) begin : gBadWord
        $error("sha1_engine: WORDSIZE must be 32");
    end

    state_t state, nextState;

    logic [3:0]          count;
    logic [6:0]          t;
    logic [159:0]        hReg;
    logic [31:0]         regA, regB, regC, regD, regE;
    logic [WORDSIZE-1:0] wReg [16];
    logic [R*32-1:0]     wCurFlat;
    logic                roundLast;

    assign roundLast = (t == 7'(NROUNDS - R));
    assign oDat      = hReg;

    // Round chain. A stage only needs a same-cycle schedule word at distance 3
    // (R <= 5 < 8), so older taps always come straight from the register file.
    for (genvar j = 0; j < R; j++) begin : gStage
        logic [31:0] aIn, bIn, cIn, dIn, eIn;
        logic [31:0] aOut, bOut, cOut, dOut, eOut;
        logic [31:0] wM3, wNew, wCur;
        logic [6:0]  tj;
        logic [3:0]  s;

        assign tj = t + 7'(j);
        assign s  = tj[3:0];

        if (j == 0) begin : gHead
            assign aIn = regA;
            assign bIn = regB;
            assign cIn = regC;
            assign dIn = regD;
            assign eIn = regE;
        end else begin : gLink
            assign aIn = gStage[j-1].aOut;
            assign bIn = gStage[j-1].bOut;
            assign cIn = gStage[j-1].cOut;
            assign dIn = gStage[j-1].dOut;
            assign eIn = gStage[j-1].eOut;
        end

        if (j >= 3) begin : gFwd
            assign wM3 = gStage[j-3].wCur;
        end else begin : gTap
            assign wM3 = wReg[s - 4'd3];
        end

        assign wNew = rotl(wM3 ^ wReg[s - 4'd8] ^ wReg[s + 4'd2] ^ wReg[s], 1);
        assign wCur = (tj < 7'd16) ? wReg[s] : wNew;
        assign wCurFlat[j*32 +: 32] = wCur;

        sha1_round uRound (
            .a    (aIn),
            .b    (bIn),
            .c    (cIn),
            .d    (dIn),
            .e    (eIn),
            .w    (wCur),
            .t    (tj),
            .aNext(aOut),
            .bNext(bOut),
            .cNext(cOut),
            .dNext(dOut),
            .eNext(eOut)
        );
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        oReady    = 1'b0;
        case (state)
            IDLE:   nextState = LOAD;
            LOAD: begin
                oReady = 1'b1;
                if (iValid && count == 4'd15) nextState = ROUND;
            end
            ROUND:  if (roundLast) nextState = UPDATE;
            UPDATE: nextState = LOAD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hReg  <= HINIT;
            regA  <= '0;
            regB  <= '0;
            regC  <= '0;
            regD  <= '0;
            regE  <= '0;
            count <= '0;
            t     <= '0;
            oDone <= 1'b0;
            for (int i = 0; i < 16; i++) wReg[i] <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                LOAD: begin
                    if (iValid) begin
                        wReg[count] <= iDat;
                        count       <= count + 4'd1;
                        if (count == 4'd0) begin
                            if (iInitial) begin
                                hReg                           <= HINIT;
                                {regA, regB, regC, regD, regE} <= HINIT;
                            end else begin
                                {regA, regB, regC, regD, regE} <= hReg;
                            end
                        end
                        if (count == 4'd15) t <= '0;
                    end
                end
                ROUND: begin
                    regA <= gStage[R-1].aOut;
                    regB <= gStage[R-1].bOut;
                    regC <= gStage[R-1].cOut;
                    regD <= gStage[R-1].dOut;
                    regE <= gStage[R-1].eOut;
                    t    <= t + 7'(R);
                    // Rewriting a slot with its own value for t < 16 is harmless.
                    for (int j = 0; j < R; j++) begin
                        wReg[4'(t[3:0] + 4'(j))] <= wCurFlat[j*32 +: 32];
                    end
                end
                UPDATE: begin
                    hReg  <= {hReg[159:128] + regA, hReg[127:96] + regB, hReg[95:64] + regC,
                              hReg[63:32] + regD, hReg[31:0] + regE};
                    oDone <= 1'b1;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_engine.sv
// Bench for sha1_engine at R = 1, 2, 4, 5 against a plain SHA-1 reference and known digests.
module tb_sha1_engine;

    typedef logic [31:0] block_t [16];

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] TWO_DIG = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         vld  [4];
    logic [31:0]  dat  [4];
    logic         ini  [4];
    logic         rdy  [4];
    logic [159:0] dig  [4];
    logic         done [4];

    int           doneCnt [4];
    logic [159:0] modelH  [4];
    int           nChecks = 0;
    int           nErrors = 0;

    always #5 iClk = ~iClk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        sha1_engine #(.ROUNDS_PER_CYCLE((g == 3) ? 5 : (1 << g)), .WORDSIZE(32)) dut (
            .iClk    (iClk),
            .iRst    (iRst),
            .iDat    (dat[g]),
            .iValid  (vld[g]),
            .iInitial(ini[g]),
            .oReady  (rdy[g]),
            .oDat    (dig[g]),
            .oDone   (done[g])
        );
    end

    always @(negedge iClk) begin
        for (int i = 0; i < 4; i++) if (done[i] === 1'b1) doneCnt[i]++;
    end

    function automatic int rOf(input int i);
        return (i == 3) ? 5 : (1 << i);
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] refCompress(input logic [159:0] h, input block_t blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int n = 0; n < 16; n++) w[n] = blk[n];
        for (int n = 16; n < 80; n++) w[n] = rol(w[n-3] ^ w[n-8] ^ w[n-14] ^ w[n-16], 1);
        {a, b, c, d, e} = h;
        for (int n = 0; n < 80; n++) begin
            if (n < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (n < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (n < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = rol(a, 5) + f + e + k + w[n];
            e = d; d = c; c = rol(b, 30); b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    task automatic checkVal(input string tag, input logic [159:0] got, input logic [159:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendBlock(input int i, input block_t blk, input logic init,
                             input int maxStall, input string tag);
        int   nStall;
        int   guard;
        int   nAcc;
        logic acc;
        nAcc = 0;
        for (int k = 0; k < 16; k++) begin
            nStall = (maxStall > 0) ? int'($urandom_range(maxStall, 0)) : 0;
            vld[i] = 1'b0;
            repeat (nStall) begin
                dat[i] = $urandom;
                @(posedge iClk); #1;
            end
            vld[i] = 1'b1;
            dat[i] = blk[k];
            ini[i] = (k == 0) ? init : 1'($urandom);
            acc    = 1'b0;
            guard  = 0;
            while (!acc && guard < 300) begin
                if (iClk) @(negedge iClk);
                acc = rdy[i];
                @(posedge iClk); #1;
                guard++;
            end
            if (acc) nAcc++;
        end
        vld[i] = 1'b0;
        checkVal({tag, " words accepted"}, 160'(nAcc), 160'(16));
    endtask

    task automatic runBlock(input int i, input block_t blk, input logic init,
                            input int maxStall, input logic garbage, input string tag);
        logic [159:0] expDig;
        int           lat;
        logic         sawRdy;
        if (init) modelH[i] = IV;
        expDig    = refCompress(modelH[i], blk);
        modelH[i] = expDig;
        sendBlock(i, blk, init, maxStall, tag);
        lat    = 0;
        sawRdy = 1'b0;
        while (lat < 200) begin
            @(negedge iClk);
            if (done[i]) break;
            if (rdy[i]) sawRdy = 1'b1;
            if (garbage) begin
                vld[i] = 1'b1;
                dat[i] = $urandom;
            end
            @(posedge iClk);
            lat++;
        end
        vld[i] = 1'b0;
        checkVal({tag, " latency"}, 160'(lat), 160'(80 / rOf(i) + 1));
        checkVal({tag, " ready in rounds"}, 160'(sawRdy), 160'(0));
        checkVal({tag, " digest"}, dig[i], expDig);
    endtask

    block_t abcBlk, twoA, twoB, rndBlk;
    int     snap;
    string  tg;

    initial begin
        abcBlk = '{default: 32'h0};
        abcBlk[0]  = 32'h61626380;
        abcBlk[15] = 32'h00000018;
        twoA = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        twoB = '{default: 32'h0};
        twoB[15] = 32'h000001c0;

        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0; dat[i] = '0; ini[i] = 1'b0; modelH[i] = IV;
        end
        iRst = 1'b0;
        #2 iRst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("reset digest R%0d", rOf(i)), dig[i], IV);
            checkVal($sformatf("reset ready R%0d", rOf(i)), 160'(rdy[i]), 160'(0));
            checkVal($sformatf("reset done R%0d", rOf(i)), 160'(done[i]), 160'(0));
        end
        @(negedge iClk) iRst = 1'b0;
        @(posedge iClk); #1;

        // Known "abc" vector at every R, no stalls.
        for (int i = 0; i < 4; i++) begin
            tg = $sformatf("abc R%0d", rOf(i));
            runBlock(i, abcBlk, 1'b1, 0, 1'b0, tg);
            checkVal({tg, " known digest"}, dig[i], ABC_DIG);
        end

        // Two-block message, chained back to back.
        for (int i = 0; i < 4; i++) begin
            @(posedge iClk); #1;
            snap = doneCnt[i];
            tg = $sformatf("two-block R%0d", rOf(i));
            runBlock(i, twoA, 1'b1, 0, 1'b0, {tg, " blk1"});
            runBlock(i, twoB, 1'b0, 0, 1'b0, {tg, " blk2"});
            checkVal({tg, " known digest"}, dig[i], TWO_DIG);
            @(posedge iClk); #1;
            checkVal({tg, " done pulses"}, 160'(doneCnt[i] - snap), 160'(2));
        end

        // "abc" with input stalls and garbage while rounds run.
        for (int i = 0; i < 4; i++) begin
            tg = $sformatf("abc stalled R%0d", rOf(i));
            runBlock(i, abcBlk, 1'b1, 5, 1'b1, tg);
            checkVal({tg, " known digest"}, dig[i], ABC_DIG);
        end

        // Random blocks, random chaining, stalls and garbage.
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k < 16; k++) rndBlk[k] = $urandom;
                runBlock(i, rndBlk, (b == 0) ? 1'b1 : 1'($urandom), 5, 1'b1,
                         $sformatf("random R%0d blk%0d", rOf(i), b));
            end
        end

        // Reset at round 40 of an "abc" block, then resend.
        @(posedge iClk); #1;
        sendBlock(0, abcBlk, 1'b1, 0, "abort abc");
        repeat (40) @(posedge iClk);
        #2 iRst = 1'b1;
        #1;
        snap = doneCnt[0];
        for (int i = 0; i < 4; i++) modelH[i] = IV;
        checkVal("abort digest on reset", dig[0], IV);
        checkVal("abort done on reset", 160'(done[0]), 160'(0));
        @(negedge iClk) iRst = 1'b0;
        #1;
        checkVal("ready after reset release", 160'(rdy[0]), 160'(0));
        @(posedge iClk); #1;
        checkVal("ready one edge after release", 160'(rdy[0]), 160'(1));
        runBlock(0, abcBlk, 1'b1, 0, 1'b0, "resent abc");
        checkVal("resent abc known digest", dig[0], ABC_DIG);
        @(posedge iClk); #1;
        checkVal("done pulses around abort", 160'(doneCnt[0] - snap), 160'(1));

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
